// File: rtl/pipelined_cla_adder_pkg.sv
// Shared types and 4-bit carry-lookahead group helpers for the pipelined
// CLA adder/subtractor.
//   aluop_t   : operation select (ADD / SUB)
//   flags_t   : result flags {cout, ovf, zero, neg}
//   cla4_pg   : group propagate/generate of a 4-bit slice, returned as {P, G}
//   cla4_sum  : 4-bit sum of a slice given its carry-in
package pipelined_cla_adder_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } aluop_t;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

  function automatic logic [1:0] cla4_pg(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] g;
    logic       gp;
    logic       gg;
    p  = a ^ b;
    g  = a & b;
    gp = &p;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gp, gg};
  endfunction

  function automatic logic [3:0] cla4_sum(input logic [3:0] a, input logic [3:0] b,
                                          input logic cin);
    logic [3:0] p;
    logic [2:0] g;
    logic [3:0] c;
    p    = a ^ b;
    g    = a[2:0] & b[2:0];
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return p ^ c;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_seg.sv
// cla_seg: combinational W-bit carry-lookahead adder built from 4-bit groups
// with a second lookahead level across the groups.
//   a, b  : W-bit operands (W a multiple of 4)
//   cin   : carry into bit 0
//   sum   : W-bit sum
//   cout  : carry out of bit W-1
//   pg/gg : segment-level propagate / generate (independent of cin)
module cla_seg
  import pipelined_cla_adder_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         pg,
  output logic         gg
);

  localparam int G = W / 4;

  logic [G-1:0] p;
  logic [G-1:0] g;
  logic [G:0]   c;

  always_comb begin
    p = '0;
    g = '0;
    for (int i = 0; i < G; i++) begin
      {p[i], g[i]} = cla4_pg(a[4*i +: 4], b[4*i +: 4]);
    end
  end

  // Each group carry is a flat sum of products over lower groups, so no
  // carry waits on the previous group's carry.
  always_comb begin
    logic carry;
    logic prod;
    carry = 1'b0;
    prod  = 1'b0;
    c     = '0;
    c[0]  = cin;
    for (int i = 0; i < G; i++) begin
      carry = 1'b0;
      for (int j = 0; j <= i; j++) begin
        prod = g[j];
        for (int m = j + 1; m <= i; m++) prod = prod & p[m];
        carry = carry | prod;
      end
      prod = cin;
      for (int m = 0; m <= i; m++) prod = prod & p[m];
      c[i+1] = carry | prod;
    end
  end

  always_comb begin
    logic gen;
    logic prod;
    gen  = 1'b0;
    prod = 1'b0;
    for (int j = 0; j < G; j++) begin
      prod = g[j];
      for (int m = j + 1; m < G; m++) prod = prod & p[m];
      gen = gen | prod;
    end
    gg = gen;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < G; i++) begin
      sum[4*i +: 4] = cla4_sum(a[4*i +: 4], b[4*i +: 4], c[i]);
    end
  end

  assign pg   = &p;
  assign cout = c[G];

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit adder/subtractor resolved one SEG_W-bit
// segment per cycle, with a valid/ready handshake and backpressure.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake
//   a, b, cin            : operands and carry-in (cin ignored for SUB)
//   op_sub               : 0 = a+b+cin, 1 = a-b
//   sat_en               : clamp to the signed range on overflow
//   out_valid / out_ready: output handshake
//   sum, cout, ovf, zero, neg : result and flags
// Rank 0 captures the operation; rank k+1 holds it after segment k resolved.
// The final rank is the output register, so latency is STAGES+1 edges
// counting the accept edge.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SEG_W = WIDTH / STAGES;

  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                input logic clamp,
                                                input logic a_msb);
    logic signed [WIDTH-1:0] s_max;
    logic signed [WIDTH-1:0] s_min;
    s_max = {1'b0, {(WIDTH-1){1'b1}}};
    s_min = {1'b1, {(WIDTH-1){1'b0}}};
    if (!clamp) return raw;
    return a_msb ? s_min : s_max;
  endfunction

  aluop_t op;
  assign op = op_sub ? SUB : ADD;

  logic [STAGES:0]   vld_p;
  logic [STAGES:0]   ld;
  logic [WIDTH-1:0]  a_p [STAGES];
  logic [WIDTH-1:0]  b_p [STAGES];
  logic [WIDTH-1:0]  s_p [STAGES];
  logic [STAGES-1:0] c_p;
  logic [STAGES-1:0] sat_p;
  logic [STAGES-1:0] unused_pg;
  logic [STAGES-1:0] unused_gg;
  flags_t            flags_q;

  // A rank loads when it, or any rank downstream of it, is empty, or when
  // the output is being taken: bubbles collapse and a full pipe still flows.
  always_comb begin
    ld = '0;
    for (int k = 0; k <= STAGES; k++) begin
      ld[k] = out_ready;
      for (int j = k; j <= STAGES; j++) begin
        if (!vld_p[j]) ld[k] = 1'b1;
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld_p[STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      if (ld[0]) vld_p[0] <= in_valid;
      for (int k = 1; k <= STAGES; k++) begin
        if (ld[k]) vld_p[k] <= vld_p[k-1];
      end
    end
  end

  // ---- rank 0: capture operands, B inverted and carry-in fixed for SUB ----
  always_ff @(posedge clk) begin
    if (ld[0]) begin
      a_p[0]   <= a;
      b_p[0]   <= (op == SUB) ? ~b : b;
      c_p[0]   <= (op == SUB) ? 1'b1 : cin;
      s_p[0]   <= '0;
      sat_p[0] <= sat_en;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [SEG_W-1:0] seg_s;
    logic             seg_c;
    logic [WIDTH-1:0] s_nxt;

    cla_seg #(.W(SEG_W)) u_seg (
      .a    (a_p[k][k*SEG_W +: SEG_W]),
      .b    (b_p[k][k*SEG_W +: SEG_W]),
      .cin  (c_p[k]),
      .sum  (seg_s),
      .cout (seg_c),
      .pg   (unused_pg[k]),
      .gg   (unused_gg[k])
    );

    always_comb begin
      s_nxt                    = s_p[k];
      s_nxt[k*SEG_W +: SEG_W] = seg_s;
    end

    if (k < STAGES - 1) begin : g_mid
      // ---- rank k+1: segment k resolved, carry and upper operands forwarded ----
      always_ff @(posedge clk) begin
        if (ld[k+1]) begin
          a_p[k+1]   <= a_p[k];
          b_p[k+1]   <= b_p[k];
          s_p[k+1]   <= s_nxt;
          c_p[k+1]   <= seg_c;
          sat_p[k+1] <= sat_p[k];
        end
      end
    end else begin : g_fin
      logic             a_msb;
      logic             b_msb;
      logic             ovf_raw;
      logic [WIDTH-1:0] sum_sat;

      assign a_msb   = a_p[k][WIDTH-1];
      assign b_msb   = b_p[k][WIDTH-1];
      assign ovf_raw = (a_msb == b_msb) && (s_nxt[WIDTH-1] != a_msb);
      assign sum_sat = saturate(s_nxt, sat_p[k] && ovf_raw, a_msb);

      // ---- output rank: final segment, flags, saturation ----
      always_ff @(posedge clk) begin
        if (rst) begin
          sum     <= '0;
          flags_q <= '0;
        end else if (ld[STAGES]) begin
          sum          <= sum_sat;
          flags_q.cout <= seg_c;
          flags_q.ovf  <= ovf_raw;
          flags_q.zero <= (sum_sat == '0);
          flags_q.neg  <= sum_sat[WIDTH-1];
        end
      end
    end
  end

  assign cout = flags_q.cout;
  assign ovf  = flags_q.ovf;
  assign zero = flags_q.zero;
  assign neg  = flags_q.neg;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=32, STAGES=2).
// A scoreboard queue holds arithmetic-model results for every accepted
// operation; a negedge process compares each presented output against it.
// Directed vectors also carry hand-computed literal expectations.
module tb_pipelined_cla_adder;

  localparam int W  = 32;
  localparam int ST = 2;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          op_sub;
  logic          sat_en;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;
  logic          zero;
  logic          neg;

  pipelined_cla_adder #(.WIDTH(W), .STAGES(ST)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic mc, input logic ms, input logic msat);
    exp_t        r;
    longint      sa;
    longint      sb;
    longint      res;
    logic [32:0] u;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (ms) begin
      r.sum  = ma - mb;
      r.cout = (ma >= mb);
      res    = sa - sb;
    end else begin
      u      = {1'b0, ma} + {1'b0, mb} + {32'b0, mc};
      r.sum  = u[31:0];
      r.cout = u[32];
      res    = sa + sb + longint'(mc);
    end
    r.ovf = (res > SMAX) || (res < SMIN);
    if (msat && r.ovf) r.sum = (res > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    r.zero = (r.sum == 32'h0);
    r.neg  = r.sum[31];
    return r;
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_out_valid", {31'b0, out_valid}, 32'h0);
      end else begin
        e = sbq[0];
        chk("sb_sum", sum, e.sum);
        chk("sb_flags", {28'b0, cout, ovf, zero, neg}, {28'b0, e.cout, e.ovf, e.zero, e.neg});
        if (out_ready) void'(sbq.pop_front());
      end
    end
    if (rst) begin
      sbq.delete();
    end else if (in_valid && in_ready) begin
      sbq.push_back(model(a, b, cin, op_sub, sat_en));
      n_acc++;
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb2, input logic tc,
                      input logic ts, input logic tsat);
    bit ok;
    ok       = 1'b0;
    a        = ta;
    b        = tb2;
    cin      = tc;
    op_sub   = ts;
    sat_en   = tsat;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string nm, input logic [31:0] ta, input logic [31:0] tb2,
                         input logic tc, input logic ts, input logic tsat,
                         input logic [31:0] e_sum, input logic e_cout, input logic e_ovf,
                         input logic e_zero, input logic e_neg);
    a        = ta;
    b        = tb2;
    cin      = tc;
    op_sub   = ts;
    sat_en   = tsat;
    in_valid = 1'b1;
    chk({nm, "_in_ready"}, {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (ST - 1) @(posedge clk);
    #1;
    chk({nm, "_not_early"}, {31'b0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    chk({nm, "_out_valid"}, {31'b0, out_valid}, 32'h1);
    chk({nm, "_sum"}, sum, e_sum);
    chk({nm, "_cout"}, {31'b0, cout}, {31'b0, e_cout});
    chk({nm, "_ovf"}, {31'b0, ovf}, {31'b0, e_ovf});
    chk({nm, "_zero"}, {31'b0, zero}, {31'b0, e_zero});
    chk({nm, "_neg"}, {31'b0, neg}, {31'b0, e_neg});
  endtask

  logic [31:0] bp_a [6] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678,
                            32'h8000_0000, 32'h0000_000A, 32'h7FFF_FFF0};
  logic [31:0] bp_b [6] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_FFFF,
                            32'h8000_0000, 32'h0000_0003, 32'h0000_0020};
  logic [4:0]  bp_c [6] = '{5'b00000, 5'b00100, 5'b00010, 5'b00001, 5'b00110, 5'b00001};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    op_sub    = 1'b0;
    sat_en    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_flags", {28'b0, cout, ovf, zero, neg}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

    run_one("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 32'h0000_0000, 1, 0, 1, 0);
    run_one("add_seg",    32'h0000_FFFF, 32'h0000_0001, 0, 0, 0, 32'h0001_0000, 0, 0, 0, 0);
    run_one("add_cin",    32'h0000_0001, 32'h0000_0001, 1, 0, 0, 32'h0000_0003, 0, 0, 0, 0);
    run_one("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0, 32'h8000_0000, 0, 1, 0, 1);
    run_one("add_sat",    32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 1, 32'h7FFF_FFFF, 0, 1, 0, 0);
    run_one("sub_neg",    32'h0000_0005, 32'h0000_0007, 0, 1, 0, 32'hFFFF_FFFE, 0, 0, 0, 1);
    run_one("sub_sat",    32'h8000_0000, 32'h0000_0001, 0, 1, 1, 32'h8000_0000, 1, 1, 0, 1);
    run_one("sub_cin_ig", 32'h0000_000A, 32'h0000_0003, 1, 1, 0, 32'h0000_0007, 1, 0, 0, 0);

    // Backpressure: six back-to-back operations with the output stalled.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    acc0      = n_acc;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(bp_a[i], bp_b[i], bp_c[i][2], bp_c[i][1], bp_c[i][0]);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
        chk("bp_out_valid_held", {31'b0, out_valid}, 32'h1);
        chk("bp_accepted_full", n_acc - acc0, ST + 1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          chk("bp_throughput", {31'b0, out_valid}, 32'h1);
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;
    chk("bp_drained", sbq.size(), 32'h0);

    // Reset with two operations in flight.
    send(32'h0000_1111, 32'h0000_2222, 0, 0, 0);
    send(32'hFFFF_0000, 32'h0001_0000, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_sum", sum, 32'h0);
    chk("mid_rst_flags", {28'b0, cout, ovf, zero, neg}, 32'h0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("mid_rst_no_stale", {31'b0, out_valid}, 32'h0);
    end
    run_one("post_rst", 32'h1234_5678, 32'h1111_1111, 0, 0, 0, 32'h2345_6789, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", sbq.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
